pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the architectural PC and sequences instruction fetch for the RISC-V core. Issues fetch requests to instruction memory over a valid/ready handshake and presents each fetched instruction to decode. On instruction retirement it selects the next PC: PC+4, the PC-relative branch/JAL target, or the JALR target. Flags misaligned targets and halts on them.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  instruction memory accepts request
imem_addr  out  32  fetch address, equal to current PC
imem_rsp_valid  in  1  fetch data valid
imem_rsp_data  in  32  fetched instruction word
instr_valid  out  1  instruction presented to decode
instr  out  32  registered instruction word
instr_pc  out  32  PC of the presented instruction
instr_ready  in  1  core retires the presented instruction this cycle
branch_taken  in  1  conditional branch resolved taken
jump  in  1  JAL
jalr  in  1  JALR
imm_ext  in  32  sign-extended immediate, already shifted for B/J
rs1_val  in  32  rs1 operand for JALR
misalign_exc  out  1  sticky misaligned-target flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low, async): state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, misalign_exc=0, instret=0, imem_req_valid=0. The first request is driven on the first rising edge after deassertion, through registered imem_req_valid.
- States: FETCH, WAIT_RSP, ISSUE, TRAP.
- FETCH: imem_req_valid=1, imem_addr=pc. Hold valid and addr stable until imem_req_ready. Valid&&ready moves to WAIT_RSP.
- WAIT_RSP: imem_req_valid=0. On imem_rsp_valid, capture instr=imem_rsp_data and instr_pc=pc, then go to ISSUE. imem_rsp_valid is ignored in every other state.
- ISSUE: instr_valid=1, instr and instr_pc held stable. On instr_ready, retire: instret+=1, compute next_pc, then go to FETCH, or TRAP if misaligned. The control inputs and imm_ext/rs1_val are sampled only in the retire cycle.
- next_pc priority:
  - jalr: (rs1_val+imm_ext) & ~32'h1.
  - else jump or branch_taken: pc+imm_ext.
  - else: pc+4.
- Adds are 32-bit modulo; carry is discarded, so 0xFFFF_FFFC+4 gives 0.
- Misaligned: next_pc[1:0]!=0 sets misalign_exc=1, leaves pc unchanged, enters TRAP. The instruction still counts as retired.
- TRAP: all valids 0, terminal until rst_n.
- Minimum loop: request accepted at cycle N, response at N+1, instr_valid at N+2, retire at N+2, next request at N+3.
- Backpressure: imem_req_ready low holds FETCH indefinitely. instr_ready low holds ISSUE indefinitely. No timeout.
- instret wraps modulo 2^CNT_W.
- Reset mid-transaction: state is lost immediately. Any response to an outstanding request arriving after reset is ignored because state=FETCH.

Decomposition:
- Shared package: state encoding constants (FETCH=2'd0, WAIT_RSP=2'd1, ISSUE=2'd2, TRAP=2'd3), PC_INCR=32'd4, RESET_PC default.
- One combinational sub-module, next_pc_calc. Inputs: pc, imm_ext, rs1_val, branch_taken, jump, jalr. Outputs: next_pc, misaligned. It contains the single PC+imm adder, the rs1+imm adder and the priority mux.
- The FSM, registers and counter stay in pc_sequencer.

Test Plan:
- Reset release, RESET_PC=0x100, imem_req_ready=1 and rsp one cycle later, instr_ready=1 with no control → imem_addr sequence 0x100, 0x104, 0x108. instret=3 after three retires.
- Retire at pc=0x200 with branch_taken=1 and imm_ext=0xFFFF_FFF8 → next request addr 0x1F8. Same with jump=1 and imm_ext=0x40 → 0x240.
- jalr=1, rs1_val=0x1001, imm_ext=0x4 → request addr 0x1004 (bit0 cleared). jalr=1 and jump=1 together → JALR target wins.
- Retire at pc=0x300 with branch_taken=1 and imm_ext=0x2 → misalign_exc=1, TRAP. No further imem_req_valid. pc stays 0x300. instret incremented.
- imem_req_ready low for 5 cycles → imem_req_valid=1 and imem_addr constant throughout. instr_ready low for 4 cycles → instr and instr_pc stable, instret unchanged.
- rst_n pulsed low in WAIT_RSP, then stale imem_rsp_valid=1 → outputs reset immediately, stale response ignored, next request addr=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and PC constants.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_RSP = 2'd1,
    ISSUE    = 2'd2,
    TRAP     = 2'd3
  } state_t;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Next-PC selection: JALR target, PC-relative target, or sequential PC+4,
// plus a misalignment flag on the selected target.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] rs1_val,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jalr,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] pc_rel;
  logic [31:0] reg_rel;

  assign pc_rel  = pc + imm_ext;
  assign reg_rel = rs1_val + imm_ext;

  always_comb begin
    next_pc = pc + PC_INCR;
    if (jalr)
      next_pc = reg_rel & ~32'h1;
    else if (jump || branch_taken)
      next_pc = pc_rel;
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: fetches over a valid/ready handshake, presents the
// instruction to decode, and advances the PC on retirement.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             instr_ready,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jalr,
  input  logic [31:0]      imm_ext,
  input  logic [31:0]      rs1_val,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] instret
);

  state_t      state, state_n;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        misaligned;
  logic        retire;

  next_pc_calc u_next_pc (
    .pc           (pc),
    .imm_ext      (imm_ext),
    .rs1_val      (rs1_val),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jalr         (jalr),
    .next_pc      (next_pc),
    .misaligned   (misaligned)
  );

  assign imem_addr = pc;

  always_comb begin
    state_n = state;
    retire  = 1'b0;
    unique case (state)
      FETCH:    if (imem_req_valid && imem_req_ready) state_n = WAIT_RSP;
      WAIT_RSP: if (imem_rsp_valid) state_n = ISSUE;
      ISSUE: begin
        if (instr_ready) begin
          retire  = 1'b1;
          state_n = misaligned ? TRAP : FETCH;
        end
      end
      TRAP:     state_n = TRAP;
      default:  state_n = FETCH;
    endcase
  end

  // Valids are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      instr          <= '0;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
      imem_req_valid <= 1'b0;
      misalign_exc   <= 1'b0;
      instret        <= '0;
    end else begin
      state          <= state_n;
      imem_req_valid <= (state_n == FETCH);
      instr_valid    <= (state_n == ISSUE);
      if (state == WAIT_RSP && imem_rsp_valid) begin
        instr    <= imem_rsp_data;
        instr_pc <= pc;
      end
      if (retire) begin
        instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
        if (misaligned)
          misalign_exc <= 1'b1;
        else
          pc <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with RESET_PC = 0x100.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch_taken;
  logic        jump;
  logic        jalr;
  logic [31:0] imm_ext;
  logic [31:0] rs1_val;
  logic        misalign_exc;
  logic [31:0] instret;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_instret;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0000_0100), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .branch_taken   (branch_taken),
    .jump           (jump),
    .jalr           (jalr),
    .imm_ext        (imm_ext),
    .rs1_val        (rs1_val),
    .misalign_exc   (misalign_exc),
    .instret        (instret)
  );

  // Waits (bounded) for a request, accepts it, answers one cycle later.
  task automatic fetch_one(input logic [31:0] data, output logic [31:0] addr);
    for (int i = 0; i < 20 && !imem_req_valid; i++) @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL fetch_timeout imem_req_valid=%b expected=1", imem_req_valid);
    end
    addr = imem_addr;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  task automatic retire(input logic bt, input logic jmp, input logic jr,
                        input logic [31:0] imm, input logic [31:0] rs1);
    branch_taken = bt; jump = jmp; jalr = jr; imm_ext = imm; rs1_val = rs1;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0; jalr = 1'b0;
    imm_ext = '0; rs1_val = '0;
    exp_instret++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0; jalr = 1'b0;
    imm_ext = '0; rs1_val = '0;
    exp_instret = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req_valid, instr_valid, misalign_exc} !== 3'b000) begin
      failures++;
      $display("FAIL reset_valids req/instr/exc=%b expected=000", {imem_req_valid, instr_valid, misalign_exc});
    end
    checks++;
    if (imem_addr !== 32'h100) begin
      failures++; $display("FAIL reset_addr got=%h expected=00000100", imem_addr);
    end
    checks++;
    if ({instr, instr_pc, instret} !== 96'h0) begin
      failures++; $display("FAIL reset_regs instr=%h instr_pc=%h instret=%0d expected=0", instr, instr_pc, instret);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      failures++; $display("FAIL first_req valid=%b addr=%h expected=1/00000100", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_sequential;
    logic [31:0] a;
    logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      d = 32'h0000_0013 + (k << 7);
      fetch_one(d, a);
      checks++;
      if (a !== 32'h100 + 32'(4 * k)) begin
        failures++; $display("FAIL seq_addr%0d got=%h expected=%h", k, a, 32'h100 + 32'(4 * k));
      end
      checks++;
      if (instr_valid !== 1'b1 || instr !== d || instr_pc !== a) begin
        failures++; $display("FAIL seq_issue%0d valid=%b instr=%h pc=%h expected=1/%h/%h", k, instr_valid, instr, instr_pc, d, a);
      end
      retire(1'b0, 1'b0, 1'b0, '0, '0);
      checks++;
      if (imem_req_valid !== 1'b1) begin
        failures++; $display("FAIL min_loop%0d imem_req_valid=%b expected=1", k, imem_req_valid);
      end
    end
    checks++;
    if (instret !== 32'd3) begin
      failures++; $display("FAIL seq_instret got=%0d expected=3", instret);
    end
    fetch_one(32'h0000_006f, a);
    retire(1'b0, 1'b1, 1'b0, 32'h0000_00F4, '0);
  endtask

  task automatic test_branch_jump;
    logic [31:0] a;
    fetch_one(32'h0000_0063, a);
    checks++;
    if (a !== 32'h200) begin failures++; $display("FAIL jump_to_200 got=%h expected=00000200", a); end
    retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, '0);
    fetch_one(32'h0000_006f, a);
    checks++;
    if (a !== 32'h1F8) begin failures++; $display("FAIL branch_back got=%h expected=000001f8", a); end
    retire(1'b0, 1'b1, 1'b0, 32'h8, '0);
    fetch_one(32'h0000_006f, a);
    retire(1'b0, 1'b1, 1'b0, 32'h40, '0);
    fetch_one(32'h0000_0067, a);
    checks++;
    if (a !== 32'h240) begin failures++; $display("FAIL jump_fwd got=%h expected=00000240", a); end
  endtask

  task automatic test_jalr;
    logic [31:0] a;
    retire(1'b0, 1'b0, 1'b1, 32'h4, 32'h1001);
    fetch_one(32'h0000_0067, a);
    checks++;
    if (a !== 32'h1004) begin failures++; $display("FAIL jalr_bit0 got=%h expected=00001004", a); end
    retire(1'b0, 1'b1, 1'b1, 32'h10, 32'h2000);
    fetch_one(32'h0000_0013, a);
    checks++;
    if (a !== 32'h2010) begin failures++; $display("FAIL jalr_priority got=%h expected=00002010", a); end
    checks++;
    if (instret !== exp_instret) begin
      failures++; $display("FAIL jalr_instret got=%0d expected=%0d", instret, exp_instret);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a;
    retire(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h2014) begin
        failures++; $display("FAIL req_hold%0d valid=%b addr=%h expected=1/00002014", i, imem_req_valid, imem_addr);
      end
      @(negedge clk);
    end
    fetch_one(32'hCAFE_0013, a);
    // Controls toggled while not retiring must have no effect on the next PC.
    branch_taken = 1'b1; jalr = 1'b1; imm_ext = 32'h80; rs1_val = 32'h4000;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0013 || instr_pc !== 32'h2014 || instret !== exp_instret) begin
        failures++;
        $display("FAIL issue_hold%0d valid=%b instr=%h pc=%h instret=%0d expected=1/cafe0013/00002014/%0d",
                 i, instr_valid, instr, instr_pc, instret, exp_instret);
      end
      @(negedge clk);
    end
    retire(1'b0, 1'b0, 1'b0, '0, '0);
    fetch_one(32'h0000_0013, a);
    checks++;
    if (a !== 32'h2018) begin failures++; $display("FAIL after_hold got=%h expected=00002018", a); end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    retire(1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF8);
    fetch_one(32'h0000_0013, a);
    checks++;
    if (a !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_jalr got=%h expected=fffffff8", a); end
    retire(1'b0, 1'b0, 1'b0, '0, '0);
    fetch_one(32'h0000_0013, a);
    retire(1'b0, 1'b0, 1'b0, '0, '0);
    fetch_one(32'h0000_0013, a);
    checks++;
    if (a !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%h expected=00000000", a); end
    retire(1'b0, 1'b1, 1'b0, 32'h300, '0);
    fetch_one(32'h0020_0063, a);
    checks++;
    if (a !== 32'h300) begin failures++; $display("FAIL to_300 got=%h expected=00000300", a); end
  endtask

  task automatic test_misalign;
    retire(1'b1, 1'b0, 1'b0, 32'h2, '0);
    checks++;
    if (misalign_exc !== 1'b1 || instret !== exp_instret) begin
      failures++; $display("FAIL misalign_flag exc=%b instret=%0d expected=1/%0d", misalign_exc, instret, exp_instret);
    end
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h300 || misalign_exc !== 1'b1) begin
        failures++;
        $display("FAIL trap_hold%0d req=%b ivalid=%b addr=%h exc=%b expected=0/0/00000300/1",
                 i, imem_req_valid, instr_valid, imem_addr, misalign_exc);
      end
      @(negedge clk);
    end
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] a;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = '0;
    @(negedge clk);
    fetch_one(32'h1111_0013, a);
    retire(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20 && !imem_req_valid; i++) @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, instr_valid, misalign_exc} !== 3'b000 || instret !== 32'd0 ||
        instr !== 32'd0 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL async_reset req=%b ivalid=%b exc=%b instret=%0d instr=%h addr=%h expected=0/0/0/0/0/00000100",
               imem_req_valid, instr_valid, misalign_exc, instret, instr, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = '0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'd0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
        failures++;
        $display("FAIL stale_rsp%0d ivalid=%b instr=%h req=%b addr=%h expected=0/0/1/00000100",
                 i, instr_valid, instr, imem_req_valid, imem_addr);
      end
    end
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    fetch_one(32'h2222_0013, a);
    checks++;
    if (a !== 32'h100 || instr !== 32'h2222_0013) begin
      failures++; $display("FAIL post_reset_fetch addr=%h instr=%h expected=00000100/22220013", a, instr);
    end
    retire(1'b0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (instret !== exp_instret) begin
      failures++; $display("FAIL post_reset_instret got=%0d expected=%0d", instret, exp_instret);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_jalr();
    test_backpressure();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
